// File: rtl/iso14443a_manchester_dec.sv
// ISO14443-A tag-response Manchester decoder: SOF detect, LSB-first bytes, optional odd parity, EOF.
// Define ISO14443A_PARITY_EN for 9-bit bytes with a checked parity bit; otherwise raw 8-bit bytes.
module iso14443a_manchester_dec #(
    parameter int unsigned SAMPLES_PER_HALF = 4,
    parameter int unsigned VOTE_MIN         = 2
) (
    input  logic       ck_1356meg,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       sample_valid,
    input  logic       curbit,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       parity_ok,
    output logic [2:0] last_bits,
    output logic       frame_start,
    output logic       frame_end,
    output logic       coding_err,
    output logic       frame_active
);

    localparam int unsigned SAMPLES_PER_BIT = 2 * SAMPLES_PER_HALF;
    localparam int unsigned SAMP_W          = $clog2(SAMPLES_PER_BIT);
    localparam int unsigned VOTE_W          = 3;
    localparam int unsigned BIT_W           = 4;
    localparam int unsigned BYTE_W          = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SOF  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [SAMP_W-1:0]   samp_cnt, samp_cnt_d;
    logic [VOTE_W-1:0]   vote_a, vote_a_d, vote_b, vote_b_d;
    logic [VOTE_W-1:0]   vote_a_nxt, vote_b_nxt;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_d;
    logic [BYTE_W-1:0]   shift_reg, shift_d;
    logic [BYTE_W-1:0]   data_byte_d;
    logic [2:0]          last_bits_d;
    logic                byte_valid_d, frame_start_d, frame_end_d, coding_err_d, frame_active_d;
    logic                in_first_half, last_sample, mod_a, mod_b;
`ifdef ISO14443A_PARITY_EN
    logic                parity_ok_d;
`endif

    // State and output registers, all on the carrier negedge like the front end.
    always_ff @(negedge ck_1356meg) begin
        if (!rst_n) begin
            state        <= IDLE;
            samp_cnt     <= '0;
            vote_a       <= '0;
            vote_b       <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            data_byte    <= '0;
            last_bits    <= '0;
            byte_valid   <= 1'b0;
            frame_start  <= 1'b0;
            frame_end    <= 1'b0;
            coding_err   <= 1'b0;
            frame_active <= 1'b0;
`ifdef ISO14443A_PARITY_EN
            parity_ok    <= 1'b0;
`endif
        end else begin
            state        <= state_d;
            samp_cnt     <= samp_cnt_d;
            vote_a       <= vote_a_d;
            vote_b       <= vote_b_d;
            bit_cnt      <= bit_cnt_d;
            shift_reg    <= shift_d;
            data_byte    <= data_byte_d;
            last_bits    <= last_bits_d;
            byte_valid   <= byte_valid_d;
            frame_start  <= frame_start_d;
            frame_end    <= frame_end_d;
            coding_err   <= coding_err_d;
            frame_active <= frame_active_d;
`ifdef ISO14443A_PARITY_EN
            parity_ok    <= parity_ok_d;
`endif
        end
    end

`ifndef ISO14443A_PARITY_EN
    assign parity_ok = 1'b1;
`endif

    // Next-state, vote accumulation and symbol decisions.
    always_comb begin
        state_d        = state;
        samp_cnt_d     = samp_cnt;
        vote_a_d       = vote_a;
        vote_b_d       = vote_b;
        bit_cnt_d      = bit_cnt;
        shift_d        = shift_reg;
        data_byte_d    = data_byte;
        last_bits_d    = last_bits;
        byte_valid_d   = 1'b0;
        frame_start_d  = 1'b0;
        frame_end_d    = 1'b0;
        coding_err_d   = 1'b0;
        frame_active_d = frame_active;
`ifdef ISO14443A_PARITY_EN
        parity_ok_d    = parity_ok;
`endif

        in_first_half = samp_cnt < SAMP_W'(SAMPLES_PER_HALF);
        last_sample   = samp_cnt == SAMP_W'(SAMPLES_PER_BIT - 1);

        // Saturating half-bit votes including the current sample.
        vote_a_nxt = vote_a;
        vote_b_nxt = vote_b;
        if (in_first_half && curbit && (vote_a < VOTE_W'(SAMPLES_PER_HALF)))
            vote_a_nxt = vote_a + VOTE_W'(1);
        if (!in_first_half && curbit && (vote_b < VOTE_W'(SAMPLES_PER_HALF)))
            vote_b_nxt = vote_b + VOTE_W'(1);
        mod_a = vote_a_nxt >= VOTE_W'(VOTE_MIN);
        mod_b = vote_b_nxt >= VOTE_W'(VOTE_MIN);

        if (!enable) begin
            state_d        = IDLE;
            samp_cnt_d     = '0;
            vote_a_d       = '0;
            vote_b_d       = '0;
            bit_cnt_d      = '0;
            frame_active_d = 1'b0;
        end else if (sample_valid) begin
            unique case (state)
                IDLE: begin
                    // First modulated sample sets the bit phase for the whole frame.
                    if (curbit) begin
                        state_d    = SOF;
                        samp_cnt_d = SAMP_W'(1);
                        vote_a_d   = VOTE_W'(1);
                        vote_b_d   = '0;
                    end
                end
                SOF, DATA: begin
                    samp_cnt_d = samp_cnt + SAMP_W'(1);
                    vote_a_d   = vote_a_nxt;
                    vote_b_d   = vote_b_nxt;
                    if (last_sample) begin
                        samp_cnt_d = '0;
                        vote_a_d   = '0;
                        vote_b_d   = '0;
                        if (state == SOF) begin
                            if (mod_a && !mod_b) begin
                                state_d        = DATA;
                                frame_start_d  = 1'b1;
                                frame_active_d = 1'b1;
                                bit_cnt_d      = '0;
                                shift_d        = '0;
                            end else begin
                                state_d = IDLE;
                            end
                        end else if (mod_a ^ mod_b) begin
`ifdef ISO14443A_PARITY_EN
                            if (bit_cnt == BIT_W'(BYTE_W)) begin
                                byte_valid_d = 1'b1;
                                data_byte_d  = shift_reg;
                                parity_ok_d  = (^shift_reg) ^ mod_a;
                                last_bits_d  = '0;
                                bit_cnt_d    = '0;
                            end else begin
                                shift_d   = {mod_a, shift_reg[BYTE_W-1:1]};
                                bit_cnt_d = bit_cnt + BIT_W'(1);
                            end
`else
                            shift_d = {mod_a, shift_reg[BYTE_W-1:1]};
                            if (bit_cnt == BIT_W'(BYTE_W - 1)) begin
                                byte_valid_d = 1'b1;
                                data_byte_d  = {mod_a, shift_reg[BYTE_W-1:1]};
                                last_bits_d  = '0;
                                bit_cnt_d    = '0;
                            end else begin
                                bit_cnt_d = bit_cnt + BIT_W'(1);
                            end
`endif
                        end else if (!mod_a) begin
                            // EOF: flush any partial byte alongside frame_end.
                            state_d        = IDLE;
                            frame_end_d    = 1'b1;
                            frame_active_d = 1'b0;
                            bit_cnt_d      = '0;
                            if (bit_cnt != '0) begin
                                byte_valid_d = 1'b1;
                                data_byte_d  = shift_reg >> (BIT_W'(BYTE_W) - bit_cnt);
                                last_bits_d  = 3'(bit_cnt);
`ifdef ISO14443A_PARITY_EN
                                parity_ok_d  = 1'b1;
                                if (bit_cnt == BIT_W'(BYTE_W)) begin
                                    data_byte_d = shift_reg;
                                    last_bits_d = '0;
                                    parity_ok_d = 1'b0;
                                end
`endif
                            end
                        end else begin
                            state_d        = IDLE;
                            coding_err_d   = 1'b1;
                            frame_active_d = 1'b0;
                            bit_cnt_d      = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
